hazard_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage RV32 core.
- Detects load-use hazards, EX-stage redirects (taken branch, jal, jalr), data-memory wait and multi-cycle MDU operations.
- Drives the enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers.
- Holds a small FSM for MDU waits with a watchdog, and saturating performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 49 ++++
 rtl/hazard_ctrl_sat_counter.sv | 35 +++
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard sequencer
package hazard_ctrl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  // Register x0 never creates a dependency
  localparam logic [4:0] REG_X0 = 5'd0;

  // Enable/flush vector for the pipeline registers
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic ex_mem_flush;
  } ctrl_t;

  // Everything frozen, nothing flushed
  localparam ctrl_t CTRL_IDLE = ctrl_t'(7'b0000000);
  // Normal flow: every register captures
  localparam ctrl_t CTRL_RUN  = ctrl_t'(7'b1101010);
  // Taken redirect: fetch new PC, squash IF/ID and ID/EX
  localparam ctrl_t CTRL_REDIR = ctrl_t'(7'b1111110);
  // Load-use: hold PC and IF/ID, bubble into ID/EX
  localparam ctrl_t CTRL_LU   = ctrl_t'(7'b0001110);
  // MDU busy: hold front end and ID/EX, bubble into EX/MEM
  localparam ctrl_t CTRL_MDU  = ctrl_t'(7'b0000011);

  // True when the load in EX produces a register the ID instruction reads
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       rs1_use,
    input logic [4:0] rs2,
    input logic       rs2_use
  );
    return mem_read && (rd != REG_X0) &&
           ((rs1_use && (rs1 == rd)) || (rs2_use && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear beats increment; stick at all-ones once reached
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline stall/flush sequencer with MDU watchdog
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [4:0]       rd_ex,
  input  logic             mem_read_ex,
  input  logic             redirect_ex,
  input  logic             dmem_wait,
  input  logic             mdu_start_ex,
  input  logic             mdu_done,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             hazard_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WD_W = $clog2(MDU_TIMEOUT) + 1;

  state_e          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  ctrl_t           ctrl;
  logic            load_use;

  assign load_use = load_use_hit(mem_read_ex, rd_ex, rs1_id, rs1_used, rs2_id, rs2_used);

  // Control vector and next-state: dmem_wait freezes everything, then redirect, MDU, load-use
  always_comb begin
    ctrl    = CTRL_IDLE;
    state_d = state_q;
    wd_d    = wd_q;
    err_d   = err_q;
    if (rst_n) begin
      unique case (state_q)
        ST_RUN: begin
          if (dmem_wait) begin
            ctrl = CTRL_IDLE;
          end else if (redirect_ex) begin
            ctrl = CTRL_REDIR;
          end else if (mdu_start_ex && !mdu_done) begin
            ctrl    = CTRL_MDU;
            state_d = ST_MDU_WAIT;
            wd_d    = WD_W'(1);
          end else if (load_use) begin
            ctrl = CTRL_LU;
          end else begin
            ctrl = CTRL_RUN;
          end
        end
        ST_MDU_WAIT: begin
          if (dmem_wait) begin
            ctrl = CTRL_IDLE;
          end else if (mdu_done) begin
            ctrl    = CTRL_RUN;
            state_d = ST_RUN;
            wd_d    = '0;
          end else begin
            ctrl = CTRL_MDU;
            wd_d = wd_q + WD_W'(1);
            if (wd_q == WD_W'(MDU_TIMEOUT - 1)) begin
              state_d = ST_HALT;
              err_d   = 1'b1;
            end
          end
        end
        default: begin
          ctrl = CTRL_IDLE;
        end
      endcase
    end
  end

  // Sequencer state, watchdog and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign pc_en        = ctrl.pc_en;
  assign if_id_en     = ctrl.if_id_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_en     = ctrl.id_ex_en;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_en    = ctrl.ex_mem_en;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign hazard_err   = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rst_n && (state_q != ST_HALT) && !ctrl.pc_en),
    .clr   (perf_clr),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl.id_ex_en && ctrl.id_ex_flush),
    .clr   (perf_clr),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int TO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4:0]    rs1_id, rs2_id, rd_ex;
  logic          rs1_used, rs2_used, mem_read_ex, redirect_ex;
  logic          dmem_wait, mdu_start_ex, mdu_done, perf_clr;
  logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush;
  logic          hazard_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .rs1_used     (rs1_used),
    .rs2_used     (rs2_used),
    .rd_ex        (rd_ex),
    .mem_read_ex  (mem_read_ex),
    .redirect_ex  (redirect_ex),
    .dmem_wait    (dmem_wait),
    .mdu_start_ex (mdu_start_ex),
    .mdu_done     (mdu_done),
    .perf_clr     (perf_clr),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_en     (id_ex_en),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_en    (ex_mem_en),
    .ex_mem_flush (ex_mem_flush),
    .hazard_err   (hazard_err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  wire [6:0] ctl  = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush};
  wire [3:0] lu_v = {pc_en, if_id_en, id_ex_en, id_ex_flush};
  wire [3:0] md_v = {pc_en, if_id_en, id_ex_en, ex_mem_flush};
  wire [4:0] rd_v = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush};

  localparam logic [6:0] EXP_RUN  = 7'b1101010;
  localparam logic [6:0] EXP_IDLE = 7'b0000000;

  task automatic idle_in();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
    rs1_used = 1'b0; rs2_used = 1'b0; mem_read_ex = 1'b0; redirect_ex = 1'b0;
    dmem_wait = 1'b0; mdu_start_ex = 1'b0; mdu_done = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic clear_counters();
    next(); idle_in(); perf_clr = 1'b1;
    next(); perf_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_in();
    samp();
    checks++; if (ctl !== EXP_IDLE) begin failures++; $display("FAIL rst_ctl got=%b exp=%b", ctl, EXP_IDLE); end
    checks++; if (hazard_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", hazard_err); end
    checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", stall_cnt); end
    checks++; if (flush_cnt !== 4'd0) begin failures++; $display("FAIL rst_flush got=%0d exp=0", flush_cnt); end
    next(); rst_n = 1'b1;
    samp();
    checks++; if (ctl !== EXP_RUN) begin failures++; $display("FAIL run_default got=%b exp=%b", ctl, EXP_RUN); end
  endtask

  task automatic test_load_use();
    next(); mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used = 1'b1;
    samp();
    checks++; if (lu_v !== 4'b0011) begin failures++; $display("FAIL lu_ctl got=%b exp=0011", lu_v); end
    next(); idle_in();
    samp();
    checks++; if (ctl !== EXP_RUN) begin failures++; $display("FAIL lu_after got=%b exp=%b", ctl, EXP_RUN); end
    checks++; if (stall_cnt !== 4'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    checks++; if (flush_cnt !== 4'd1) begin failures++; $display("FAIL lu_flush_cnt got=%0d exp=1", flush_cnt); end
  endtask

  task automatic test_x0_and_rs2();
    next(); mem_read_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; rs1_used = 1'b1;
    samp();
    checks++; if (ctl !== EXP_RUN) begin failures++; $display("FAIL x0_no_stall got=%b exp=%b", ctl, EXP_RUN); end
    next(); rd_ex = 5'd7; rs1_id = 5'd3; rs2_id = 5'd7; rs2_used = 1'b1;
    samp();
    checks++; if (lu_v !== 4'b0011) begin failures++; $display("FAIL rs2_lu got=%b exp=0011", lu_v); end
    next(); rs2_used = 1'b0;
    samp();
    checks++; if (ctl !== EXP_RUN) begin failures++; $display("FAIL rs2_unused got=%b exp=%b", ctl, EXP_RUN); end
    checks++; if (stall_cnt !== 4'd2) begin failures++; $display("FAIL rs2_stall_cnt got=%0d exp=2", stall_cnt); end
    clear_counters();
    samp();
    checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL clr_stall got=%0d exp=0", stall_cnt); end
    checks++; if (flush_cnt !== 4'd0) begin failures++; $display("FAIL clr_flush got=%0d exp=0", flush_cnt); end
  endtask

  task automatic test_redirect();
    next(); mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used = 1'b1; redirect_ex = 1'b1;
    samp();
    checks++; if (rd_v !== 5'b11111) begin failures++; $display("FAIL redirect_ctl got=%b exp=11111", rd_v); end
    next(); idle_in();
    samp();
    checks++; if (flush_cnt !== 4'd1) begin failures++; $display("FAIL redirect_flush_cnt got=%0d exp=1", flush_cnt); end
    checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL redirect_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_mdu();
    next(); mdu_start_ex = 1'b1;
    for (int i = 0; i < 4; i++) begin
      samp();
      checks++; if (md_v !== 4'b0001) begin failures++; $display("FAIL mdu_stall[%0d] got=%b exp=0001", i, md_v); end
      next();
    end
    mdu_done = 1'b1;
    samp();
    checks++; if (ctl !== EXP_RUN) begin failures++; $display("FAIL mdu_done_ctl got=%b exp=%b", ctl, EXP_RUN); end
    next(); idle_in();
    samp();
    checks++; if (ctl !== EXP_RUN) begin failures++; $display("FAIL mdu_back_run got=%b exp=%b", ctl, EXP_RUN); end
    checks++; if (stall_cnt !== 4'd4) begin failures++; $display("FAIL mdu_stall_cnt got=%0d exp=4", stall_cnt); end
  endtask

  task automatic test_timeout();
    clear_counters();
    mdu_start_ex = 1'b1;
    for (int i = 0; i < TO; i++) begin
      samp();
      checks++; if (md_v !== 4'b0001) begin failures++; $display("FAIL to_stall[%0d] got=%b exp=0001", i, md_v); end
      checks++; if (hazard_err !== 1'b0) begin failures++; $display("FAIL to_err_early[%0d] got=%b exp=0", i, hazard_err); end
      next();
    end
    samp();
    checks++; if (ctl !== EXP_IDLE) begin failures++; $display("FAIL halt_ctl got=%b exp=%b", ctl, EXP_IDLE); end
    checks++; if (hazard_err !== 1'b1) begin failures++; $display("FAIL halt_err got=%b exp=1", hazard_err); end
    checks++; if (stall_cnt !== 4'd8) begin failures++; $display("FAIL halt_stall_cnt got=%0d exp=8", stall_cnt); end
    next(); mdu_start_ex = 1'b0; redirect_ex = 1'b1;
    next();
    samp();
    checks++; if (ctl !== EXP_IDLE) begin failures++; $display("FAIL halt_hold got=%b exp=%b", ctl, EXP_IDLE); end
    checks++; if (stall_cnt !== 4'd8) begin failures++; $display("FAIL halt_no_count got=%0d exp=8", stall_cnt); end
    next(); rst_n = 1'b0; idle_in();
    samp();
    checks++; if (hazard_err !== 1'b0) begin failures++; $display("FAIL halt_rst_err got=%b exp=0", hazard_err); end
    checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL halt_rst_cnt got=%0d exp=0", stall_cnt); end
    next(); rst_n = 1'b1;
    samp();
    checks++; if (ctl !== EXP_RUN) begin failures++; $display("FAIL halt_rst_run got=%b exp=%b", ctl, EXP_RUN); end
  endtask

  task automatic test_done_at_timeout();
    next(); mdu_start_ex = 1'b1;
    for (int i = 0; i < TO - 1; i++) begin
      samp();
      checks++; if (md_v !== 4'b0001) begin failures++; $display("FAIL dt_stall[%0d] got=%b exp=0001", i, md_v); end
      next();
    end
    mdu_done = 1'b1;
    samp();
    checks++; if (ctl !== EXP_RUN) begin failures++; $display("FAIL dt_done_ctl got=%b exp=%b", ctl, EXP_RUN); end
    next(); idle_in();
    samp();
    checks++; if (hazard_err !== 1'b0) begin failures++; $display("FAIL dt_err got=%b exp=0", hazard_err); end
    checks++; if (ctl !== EXP_RUN) begin failures++; $display("FAIL dt_run got=%b exp=%b", ctl, EXP_RUN); end
  endtask

  task automatic test_dmem_wait();
    clear_counters();
    mem_read_ex = 1'b1; rd_ex = 5'd9; rs2_id = 5'd9; rs2_used = 1'b1; dmem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      samp();
      checks++; if (ctl !== EXP_IDLE) begin failures++; $display("FAIL dw_lu_freeze[%0d] got=%b exp=%b", i, ctl, EXP_IDLE); end
      next();
    end
    dmem_wait = 1'b0;
    samp();
    checks++; if (lu_v !== 4'b0011) begin failures++; $display("FAIL dw_lu_resume got=%b exp=0011", lu_v); end
    next(); idle_in();
    samp();
    checks++; if (stall_cnt !== 4'd4) begin failures++; $display("FAIL dw_stall_cnt got=%0d exp=4", stall_cnt); end
    checks++; if (flush_cnt !== 4'd1) begin failures++; $display("FAIL dw_flush_cnt got=%0d exp=1", flush_cnt); end
    next(); mdu_start_ex = 1'b1;
    for (int i = 0; i < 2; i++) begin
      samp();
      checks++; if (md_v !== 4'b0001) begin failures++; $display("FAIL dw_mdu_pre[%0d] got=%b exp=0001", i, md_v); end
      next();
    end
    dmem_wait = 1'b1;
    for (int i = 0; i < 5; i++) begin
      samp();
      checks++; if (ctl !== EXP_IDLE) begin failures++; $display("FAIL dw_mdu_freeze[%0d] got=%b exp=%b", i, ctl, EXP_IDLE); end
      next();
    end
    dmem_wait = 1'b0;
    for (int i = 0; i < TO - 2; i++) begin
      samp();
      checks++; if (md_v !== 4'b0001) begin failures++; $display("FAIL dw_mdu_post[%0d] got=%b exp=0001", i, md_v); end
      checks++; if (hazard_err !== 1'b0) begin failures++; $display("FAIL dw_err_early[%0d] got=%b exp=0", i, hazard_err); end
      next();
    end
    samp();
    checks++; if (hazard_err !== 1'b1) begin failures++; $display("FAIL dw_halt_err got=%b exp=1", hazard_err); end
    checks++; if (ctl !== EXP_IDLE) begin failures++; $display("FAIL dw_halt_ctl got=%b exp=%b", ctl, EXP_IDLE); end
    next(); rst_n = 1'b0; idle_in();
    next(); rst_n = 1'b1;
    samp();
    checks++; if (ctl !== EXP_RUN) begin failures++; $display("FAIL dw_rst_run got=%b exp=%b", ctl, EXP_RUN); end
  endtask

  task automatic test_saturate();
    next(); dmem_wait = 1'b1;
    for (int i = 0; i < 20; i++) next();
    samp();
    checks++; if (stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_stall got=%0d exp=15", stall_cnt); end
    next(); perf_clr = 1'b1;
    next(); perf_clr = 1'b0; dmem_wait = 1'b0;
    samp();
    checks++; if (stall_cnt !== 4'd0) begin failures++; $display("FAIL sat_clr_wins got=%0d exp=0", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_and_rs2();
    test_redirect();
    test_mdu();
    test_timeout();
    test_done_at_timeout();
    test_dmem_wait();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
